// File: rtl/fpu_cmd_queue_if.sv
// Bundle of every ready/valid channel around fpu_cmd_queue: client command/response
// channels plus the operand/result channels facing fpu_top.
interface fpu_cmd_queue_if #(
  parameter int TAG_W        = 4,
  parameter int MAX_INFLIGHT = 4
);
  logic                          cmd_val;
  logic                          cmd_rdy;
  logic [31:0]                   cmd_bits_A;
  logic [31:0]                   cmd_bits_B;
  logic [1:0]                    cmd_sel;
  logic [TAG_W-1:0]              cmd_tag;

  logic                          operands_val;
  logic                          operands_rdy;
  logic [31:0]                   operands_bits_A;
  logic [31:0]                   operands_bits_B;
  logic [1:0]                    operands_sel;

  logic                          result_val;
  logic [31:0]                   result_bits;
  logic                          result_rdy;

  logic                          resp_val;
  logic                          resp_rdy;
  logic [31:0]                   resp_bits;
  logic [TAG_W-1:0]              resp_tag;
  logic                          resp_err;
  logic [$clog2(MAX_INFLIGHT):0] inflight_cnt;

  // The queue's own view of the bundle.
  modport slave (
    input  cmd_val, cmd_bits_A, cmd_bits_B, cmd_sel, cmd_tag,
    output cmd_rdy,
    output operands_val, operands_bits_A, operands_bits_B, operands_sel,
    input  operands_rdy,
    input  result_val, result_bits,
    output result_rdy,
    output resp_val, resp_bits, resp_tag, resp_err, inflight_cnt,
    input  resp_rdy
  );

  // The surroundings: command source, fpu_top and response consumer.
  modport master (
    output cmd_val, cmd_bits_A, cmd_bits_B, cmd_sel, cmd_tag,
    input  cmd_rdy,
    input  operands_val, operands_bits_A, operands_bits_B, operands_sel,
    output operands_rdy,
    output result_val, result_bits,
    input  result_rdy,
    input  resp_val, resp_bits, resp_tag, resp_err, inflight_cnt,
    output resp_rdy
  );
endinterface

// File: rtl/fpu_cmd_queue.sv
// Issue/retire front end for fpu_top: a command FIFO feeding the operand port and a
// tag FIFO that pairs in-order results (or locally retired illegal ops) with their tags.
module fpu_cmd_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int TAG_W        = 4
) (
  input  logic          clk,
  input  logic          reset,
  fpu_cmd_queue_if.slave bus
);
  localparam int CP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CC_W = $clog2(DEPTH) + 1;
  localparam int TP_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int TC_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Command FIFO storage and state
  logic [31:0]      a_mem    [DEPTH];
  logic [31:0]      b_mem    [DEPTH];
  logic [1:0]       sel_mem  [DEPTH];
  logic [TAG_W-1:0] ctag_mem [DEPTH];
  logic [CP_W-1:0]  cmd_wr_ptr_reg, cmd_rd_ptr_reg;
  logic [CC_W-1:0]  cmd_cnt_reg;

  // Tag FIFO entries are {err, tag}
  logic [TAG_W:0]   tf_mem [MAX_INFLIGHT];
  logic [TP_W-1:0]  tag_wr_ptr_reg, tag_rd_ptr_reg;
  logic [TC_W-1:0]  tag_cnt_reg;

  logic cmd_empty, cmd_full, tag_empty, tag_full;
  logic cmd_push, cmd_pop, tag_push, tag_pop;
  logic head_illegal, issue_ok, fire, bypass;
  logic [1:0]       head_sel;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W:0]   tf_head;

  assign cmd_empty = (cmd_cnt_reg == '0);
  assign cmd_full  = (cmd_cnt_reg == CC_W'(DEPTH));
  assign tag_empty = (tag_cnt_reg == '0);
  assign tag_full  = (tag_cnt_reg == TC_W'(MAX_INFLIGHT));

  assign bus.cmd_rdy = !reset && !cmd_full;
  assign cmd_push    = bus.cmd_val && bus.cmd_rdy;

  assign head_sel     = sel_mem[cmd_rd_ptr_reg];
  assign head_tag     = ctag_mem[cmd_rd_ptr_reg];
  assign head_illegal = (head_sel == 2'b11);
  assign issue_ok     = !reset && !cmd_empty && !tag_full;

  assign bus.operands_val    = issue_ok && !head_illegal;
  assign bus.operands_bits_A = a_mem[cmd_rd_ptr_reg];
  assign bus.operands_bits_B = b_mem[cmd_rd_ptr_reg];
  // An illegal head is never presented, so its 11 encoding is masked off the port.
  assign bus.operands_sel    = head_illegal ? 2'b00 : head_sel;

  assign fire     = bus.operands_val && bus.operands_rdy;
  assign bypass   = issue_ok && head_illegal;
  assign cmd_pop  = fire || bypass;
  assign tag_push = cmd_pop;

  assign tf_head = tf_mem[tag_rd_ptr_reg];

  // Response mux: error entries answer locally, others wait for fpu_top's result.
  always_comb begin
    bus.resp_val   = 1'b0;
    bus.resp_bits  = bus.result_bits;
    bus.resp_err   = 1'b0;
    bus.result_rdy = 1'b0;
    bus.resp_tag   = tf_head[TAG_W-1:0];
    if (!reset && !tag_empty) begin
      if (tf_head[TAG_W]) begin
        bus.resp_val  = 1'b1;
        bus.resp_bits = CANON_NAN;
        bus.resp_err  = 1'b1;
      end else begin
        bus.resp_val   = bus.result_val;
        bus.result_rdy = bus.resp_rdy;
      end
    end
  end

  assign tag_pop          = bus.resp_val && bus.resp_rdy;
  assign bus.inflight_cnt = reset ? '0 : tag_cnt_reg;

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      a_mem[cmd_wr_ptr_reg]    <= bus.cmd_bits_A;
      b_mem[cmd_wr_ptr_reg]    <= bus.cmd_bits_B;
      sel_mem[cmd_wr_ptr_reg]  <= bus.cmd_sel;
      ctag_mem[cmd_wr_ptr_reg] <= bus.cmd_tag;
    end
    if (tag_push) begin
      tf_mem[tag_wr_ptr_reg] <= {head_illegal, head_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
      cmd_cnt_reg    <= '0;
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      tag_cnt_reg    <= '0;
    end else begin
      if (cmd_push)
        cmd_wr_ptr_reg <= (cmd_wr_ptr_reg == CP_W'(DEPTH - 1)) ? '0 : cmd_wr_ptr_reg + 1'b1;
      if (cmd_pop)
        cmd_rd_ptr_reg <= (cmd_rd_ptr_reg == CP_W'(DEPTH - 1)) ? '0 : cmd_rd_ptr_reg + 1'b1;
      cmd_cnt_reg <= cmd_cnt_reg + CC_W'(cmd_push) - CC_W'(cmd_pop);

      if (tag_push)
        tag_wr_ptr_reg <= (tag_wr_ptr_reg == TP_W'(MAX_INFLIGHT - 1)) ? '0 : tag_wr_ptr_reg + 1'b1;
      if (tag_pop)
        tag_rd_ptr_reg <= (tag_rd_ptr_reg == TP_W'(MAX_INFLIGHT - 1)) ? '0 : tag_rd_ptr_reg + 1'b1;
      tag_cnt_reg <= tag_cnt_reg + TC_W'(tag_push) - TC_W'(tag_pop);
    end
  end
endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Bench for fpu_cmd_queue: a latency-1 FPU model plus an in-order scoreboard of
// expected {err, tag, bits} responses.
module tb_fpu_cmd_queue;
  localparam int DEPTH        = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int TAG_W        = 4;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_cmd_queue_if #(.TAG_W(TAG_W), .MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

  fpu_cmd_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          op_fires    = 0;
  int          resp_count  = 0;
  int          resp_mode   = 1;   // 0: hold resp_rdy low, 1: high, 2: random
  logic [63:0] sb [$];
  logic [31:0] fpu_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single -> double for normal/zero operands
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else                  d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Double -> single with round-to-nearest-even (results stay in the normal range)
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [10:0] es;
    logic [31:0] base;
    logic [28:0] rem;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    es   = e - 11'd896;
    base = {d[63], es[7:0], d[51:29]};
    rem  = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && base[0])) base = base + 32'd1;
    return base;
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] sel);
    case (sel)
      2'b00:   return r2s(s2r(a) + s2r(b));
      2'b01:   return r2s(s2r(a) - s2r(b));
      2'b10:   return r2s(s2r(a) * s2r(b));
      default: return CANON_NAN;
    endcase
  endfunction

  function automatic logic [31:0] canon(input logic [31:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return CANON_NAN;
    if (x[30:0] == 31'd0) return 32'd0;
    return x;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'($urandom_range(110, 140));
    m = 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  // FPU model and response monitor; samples on negedge, updates just after posedge
  initial begin : env
    logic        op_f, res_f, rsp_f, rst_s;
    logic [31:0] r;
    logic [63:0] got, exp;
    bus.result_val  = 1'b0;
    bus.result_bits = 32'd0;
    bus.resp_rdy    = 1'b0;
    r = 32'd0;
    forever begin
      @(negedge clk);
      rst_s = reset;
      op_f  = bus.operands_val && bus.operands_rdy;
      res_f = bus.result_val && bus.result_rdy;
      rsp_f = bus.resp_val && bus.resp_rdy;
      if (op_f) begin
        op_fires++;
        check("op_sel_legal", 64'(bus.operands_sel != 2'b11), 64'd1);
        r = fp_ref(bus.operands_bits_A, bus.operands_bits_B, bus.operands_sel);
      end
      if (rsp_f) begin
        resp_count++;
        $display("resp tag=%0d bits=%h err=%b", bus.resp_tag, bus.resp_bits, bus.resp_err);
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          got = {27'd0, bus.resp_err, bus.resp_tag, canon(bus.resp_bits)};
          check("resp", got, exp);
        end
      end
      @(posedge clk);
      #1;
      if (rst_s) fpu_q.delete();
      else begin
        if (res_f && fpu_q.size() != 0) void'(fpu_q.pop_front());
        if (op_f) fpu_q.push_back(r);
      end
      bus.result_val  = (fpu_q.size() != 0);
      bus.result_bits = (fpu_q.size() != 0) ? fpu_q[0] : 32'd0;
      case (resp_mode)
        0:       bus.resp_rdy = 1'b0;
        1:       bus.resp_rdy = 1'b1;
        default: bus.resp_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    bit accepted = 1'b0;
    bus.cmd_bits_A = a;
    bus.cmd_bits_B = b;
    bus.cmd_sel    = sel;
    bus.cmd_tag    = tag;
    bus.cmd_val    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_rdy) begin
        sb.push_back({27'd0, (sel == 2'b11), tag, canon(exp)});
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("cmd_accept", 64'(accepted), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_val = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin : main
    logic [31:0] a, b;
    logic [1:0]  sel;
    int          base_fires, base_resps;
    reset            = 1'b1;
    bus.cmd_val      = 1'b0;
    bus.cmd_bits_A   = 32'd0;
    bus.cmd_bits_B   = 32'd0;
    bus.cmd_sel      = 2'b00;
    bus.cmd_tag      = '0;
    bus.operands_rdy = 1'b1;
    step(3);

    // Reset state
    @(negedge clk);
    check("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
    check("rst_op_val", 64'(bus.operands_val), 64'd0);
    check("rst_resp", {62'd0, bus.resp_val, bus.resp_err}, 64'd0);
    check("rst_inflight", 64'(bus.inflight_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("cmd_rdy_after_rst", 64'(bus.cmd_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Single add, issued the cycle after acceptance
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd3, 32'h4000_0000);
    @(negedge clk);
    check("t1_op_val", 64'(bus.operands_val), 64'd1);
    @(posedge clk);
    #1;
    drain(50);

    // Illegal command in the middle of a stream
    base_fires = op_fires;
    send(32'h4020_0000, 32'h3FA0_0000, 2'b01, 4'd1, 32'h3FA0_0000);
    send(32'h4020_0000, 32'h3FA0_0000, 2'b11, 4'd2, CANON_NAN);
    send(32'h3FC0_0000, 32'h4000_0000, 2'b10, 4'd3, 32'h4040_0000);
    drain(50);
    check("t2_fpu_issues", 64'(op_fires - base_fires), 64'd2);

    // Fill with responses blocked
    resp_mode = 0;
    step(1);
    base_resps = resp_count;
    for (int i = 0; i < 8; i++) begin
      a   = 32'h3F80_0000 + (32'(i) << 20);
      sel = 2'(i % 3);
      send(a, 32'h4000_0000, sel, 4'(i), fp_ref(a, 32'h4000_0000, sel));
    end
    step(4);
    @(negedge clk);
    check("fill_inflight", 64'(bus.inflight_cnt), 64'd4);
    check("fill_cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
    @(posedge clk);
    #1;
    resp_mode = 1;
    drain(100);
    check("fill_resp_count", 64'(resp_count - base_resps), 64'd8);

    // Operand stall: head held stable while operands_rdy is low
    bus.operands_rdy = 1'b0;
    send(32'h4040_0000, 32'h3F80_0000, 2'b01, 4'd9, 32'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_val", 64'(bus.operands_val), 64'd1);
      check("stall_ops", {30'd0, bus.operands_sel, bus.operands_bits_A, bus.operands_bits_B},
            {30'd0, 2'b01, 32'h4040_0000, 32'h3F80_0000});
      check("stall_inflight", 64'(bus.inflight_cnt), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.operands_rdy = 1'b1;
    @(negedge clk);
    check("stall_release_val", 64'(bus.operands_val), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_fired", 64'(bus.inflight_cnt), 64'd1);
    @(posedge clk);
    #1;
    drain(50);

    // Random stream with random response back-pressure
    resp_mode = 2;
    step(1);
    for (int i = 0; i < 20; i++) begin
      a   = rnd_fp();
      b   = rnd_fp();
      sel = 2'($urandom_range(0, 2));
      send(a, b, sel, 4'(i), fp_ref(a, b, sel));
    end
    drain(500);
    resp_mode = 1;
    step(1);

    // Reset with 2 in flight and 3 queued
    resp_mode = 0;
    step(1);
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd0, 32'h4000_0000);
    send(32'h3F80_0000, 32'h4000_0000, 2'b10, 4'd1, 32'h4000_0000);
    for (int i = 0; i < 50 && bus.inflight_cnt != 2; i++) step(1);
    bus.operands_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'(i + 2), 32'h4000_0000);
    @(negedge clk);
    check("pre_rst_inflight", 64'(bus.inflight_cnt), 64'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    step(1);
    @(negedge clk);
    check("mid_rst_resp_val", 64'(bus.resp_val), 64'd0);
    check("mid_rst_op_val", 64'(bus.operands_val), 64'd0);
    check("mid_rst_inflight", 64'(bus.inflight_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.operands_rdy = 1'b1;
    resp_mode = 1;
    step(2);
    send(32'h4000_0000, 32'hBF80_0000, 2'b10, 4'd5, 32'hC000_0000);
    drain(50);
    @(negedge clk);
    check("final_inflight", 64'(bus.inflight_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpu_cmd_queue.md
Name: fpu_cmd_queue

Overview:
- Front-end issue stage that sits directly upstream of fpu_top and connects to both of its ready/valid interfaces.
- Buffers tagged FP commands in a DEPTH-entry FIFO and issues them to fpu_top's operand port.
- Pairs each result returned on fpu_top's result port with the tag of its command, in issue order.
- Retires commands with an illegal opcode locally, never sending them to the FPU, with a canonical NaN and an error flag; program order is preserved.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- MAX_INFLIGHT, 4, tag-FIFO entries (commands issued or bypassed but not yet responded); power of two, ≥1.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_val  in  1  command valid.
- cmd_rdy  out  1  command FIFO can accept.
- cmd_bits_A  in  32  IEEE-754 single operand A.
- cmd_bits_B  in  32  IEEE-754 single operand B.
- cmd_sel  in  2  00=add, 01=sub, 10=mul, 11=illegal.
- cmd_tag  in  TAG_W  request tag.
- operands_val  out  1  to fpu_top.
- operands_rdy  in  1  from fpu_top.
- operands_bits_A  out  32  to fpu_top.
- operands_bits_B  out  32  to fpu_top.
- operands_sel  out  2  to fpu_top; never 11.
- result_val  in  1  from fpu_top.
- result_bits  in  32  from fpu_top.
- result_rdy  out  1  to fpu_top.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response consumer ready.
- resp_bits  out  32  result, or 32'h7FC0_0000 on error.
- resp_tag  out  TAG_W  tag of the responding command.
- resp_err  out  1  1 = illegal opcode.
- inflight_cnt  out  $clog2(MAX_INFLIGHT)+1  current tag-FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high): both FIFOs empty, pointers and counts 0.
  - Outputs held at 0 during reset: operands_val, resp_val, resp_err, inflight_cnt.
  - cmd_rdy is 0 while reset=1 and 1 in the first cycle after reset deasserts.
- Reset mid-operation flushes every queued and in-flight entry. fpu_top shares the same reset, so nothing orphaned returns.
- Command FIFO:
  - Push when cmd_val && cmd_rdy.
  - cmd_rdy = !cmd_full; no pass-through when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - A command pushed at edge N is visible at the head at N+1, so it is issuable no earlier than cycle N+1.
- Issue stage, evaluated on the command-FIFO head:
  - Legal head (sel≠11): operands_val = !cmd_empty && !tag_full. Operand and sel outputs are driven directly from the head entry.
  - Fire = operands_val && operands_rdy. Fire pops the command FIFO and pushes {tag, err=0} into the tag FIFO.
  - Illegal head (sel=11): operands_val=0. When !tag_full, pop the head and push {tag, err=1}; no handshake with fpu_top.
  - operands_val and the operand/sel outputs stay stable while operands_rdy=0; they never change before a fire.
  - Tag FIFO full: issue stalls and operands_val=0.
- Response stage, evaluated on the tag-FIFO head:
  - err=1 at head: resp_val = 1; resp_bits = 32'h7FC0_0000; resp_err = 1; result_rdy = 0.
  - err=0 at head: resp_val = result_val; resp_bits = result_bits; resp_err = 0; result_rdy = resp_rdy.
  - resp_tag = tag at the head.
  - The result path is combinational: zero added latency from result_val to resp_val.
  - Tag FIFO empty: resp_val = 0 and result_rdy = 0. A result_val with no outstanding tag is a protocol violation and stalls the FPU; it is never dropped.
  - Tag-FIFO pop on resp_val && resp_rdy.
  - Push and pop in the same cycle are allowed; pointers wrap modulo MAX_INFLIGHT.
- Ordering: responses appear strictly in command-acceptance order. An illegal command waits behind earlier in-flight FPU results.
- inflight_cnt = tag-FIFO occupancy, registered, range 0..MAX_INFLIGHT.
- No arithmetic on operand data; A, B and results pass through bit-exact.

Test Plan:
- Single add: cmd A=3F80_0000, B=3F80_0000, sel=00, tag=3, resp_rdy=1 -> operands_val rises the cycle after acceptance; resp_val with resp_bits=4000_0000, resp_tag=3, resp_err=0.
- Illegal in stream: tags 1 (2.5−1.25, sel=01), 2 (sel=11), 3 (1.5×2.0, sel=10) -> responses in order:
  - tag 1: 3FA0_0000, err=0;
  - tag 2: 7FC0_0000, err=1, never seen on operands_val;
  - tag 3: 4040_0000, err=0.
- Fill/backpressure: resp_rdy=0 and 8 commands pushed -> inflight_cnt saturates at 4, command FIFO fills, cmd_rdy=0. Release resp_rdy -> all 8 responses arrive in tag order 0..7 with correct results.
- Operand stall: hold operands_rdy=0 for 5 cycles with a valid head -> operands_val=1 and A/B/sel stable throughout, no pop. Fire on the first rdy cycle.
- Wrap-around: 20 back-to-back random normalized add/sub/mul commands with random resp_rdy gaps -> results match the shortreal reference model, ±0 and NaN treated equal; tags in order.
- Reset mid-stream: assert reset with 3 queued and 2 in flight -> next cycle resp_val=0, operands_val=0, inflight_cnt=0. After release, a new 2.0×(−1.0) command returns C000_0000.
